mem_scan_reader: RTL and testbench

- Read-side companion to the switch-driven block-RAM writer on the Basys board.
- Drives port B of the dual-port block memory (enb/addrb/doutb) and sweeps a programmable address window, one word at a time.
- Presents each word on a held output for LED or seven-segment display, with a valid pulse.
- Advances either on a manual step pulse or automatically after a dwell count.

---
 rtl/mem_scan_pkg.sv | 18 +
 rtl/dwell_timer.sv | 39 +++
 rtl/mem_scan_reader.sv | 202 ++++++++++++++++++++
 tb/tb_mem_scan_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_scan_pkg.sv
// Shared definitions for the block-RAM scan reader.
// Holds the FSM state type, default widths and read-latency limits.
package mem_scan_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHOW,
        FIN
    } scan_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for display blocks: counts enabled cycles after a clear.
// Ports: clk_i, rst_i (async, active-high), clr_i, en_i, expire_o.
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturate at the terminal count so expiry stays visible if the
    // owner only starts honouring it later (e.g. mode switched mid-hold).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_scan_reader.sv
// Sweeps a window of block-RAM port B and holds each word for display.
// Ports: CLK, RST, start, step, auto_mode, base_addr, length in;
//   enb, addrb, data_out, data_valid, busy, done out; doutb in.
// Build option SCAN_LOOP_EN: loop the window forever, start stops it.
module mem_scan_reader
    import mem_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int DWELL  = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              step,
    input  logic              auto_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    scan_state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lat_q, lat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic lat_last;
    logic last_word;
    logic in_show;
    logic dwell_clr;
    logic dwell_exp;
    logic advance;

    assign lat_last  = (lat_q == 2'(RD_LAT - 1));
    assign last_word = (idx_q == len_q - 1'b1);
    assign in_show   = (state_q == SHOW);
    assign dwell_clr = (state_q == WAIT) && lat_last;
    assign advance   = in_show &&
                       ((auto_mode && dwell_exp) || (!auto_mode && step));

`ifdef SCAN_LOOP_EN
    logic stop;
    assign stop = start && (state_q != IDLE);
`endif

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (dwell_clr),
        .en_i    (in_show),
        .expire_o(dwell_exp)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                if (lat_last) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (advance) begin
`ifdef SCAN_LOOP_EN
                    state_d = FETCH;
`else
                    state_d = last_word ? FIN : FETCH;
`endif
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SCAN_LOOP_EN
        if (stop) begin
            state_d = IDLE;
        end
`endif
    end

    always_comb begin
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        enb     = (state_q == FETCH);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = length;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (length != '0) begin
                        addr_d = base_addr;
                    end
                end
            end
            FETCH: lat_d = '0;
            WAIT: begin
                lat_d = lat_q + 1'b1;
                if (lat_last) begin
                    lat_d   = '0;
                    data_d  = doutb;
                    valid_d = 1'b1;
                end
            end
            SHOW: begin
                if (advance) begin
                    if (last_word) begin
`ifdef SCAN_LOOP_EN
                        idx_d  = '0;
                        addr_d = base_q;
                        done_d = 1'b1;
`endif
                    end else begin
                        // Natural ADDR_W overflow gives the wrap to 0.
                        idx_d  = idx_q + 1'b1;
                        addr_d = base_q + idx_d;
                    end
                end
            end
            FIN: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
`ifdef SCAN_LOOP_EN
        if (stop) begin
            busy_d = 1'b0;
            done_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addrb      = addr_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Self-checking bench for mem_scan_reader (RD_LAT=2, DWELL=5).
// Randomised scans are checked against a cycle-timing model of the sweep.
module tb_mem_scan_reader;

    localparam int RL = 2;
    localparam int DW = 5;
    localparam int NB = 16384;

    typedef struct {
        int          c;
        logic [15:0] v;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        auto_mode = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  length = '0;
    logic        enb;
    logic [9:0]  addrb;
    logic [15:0] doutb;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:1023];
    logic [15:0] r1 = '0;
    logic [15:0] r2 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sc = 0;
    logic [15:0] last_d = '0;

    ev_t fq[$];
    ev_t vq[$];
    int  dq[$];
    bit  busy_seen [NB];
    bit  busy_exp [NB];
    bit  step_at [NB];

    mem_scan_reader #(
        .ADDR_W(10),
        .DATA_W(16),
        .RD_LAT(RL),
        .DWELL (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .step      (step),
        .auto_mode (auto_mode),
        .base_addr (base_addr),
        .length    (length),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Two-stage block-RAM read path on port B.
    always @(posedge CLK) begin
        if (enb) r1 <= mem[addrb];
        r2 <= r1;
    end
    assign doutb = r2;

    always @(negedge CLK) begin
        if (enb) fq.push_back('{cyc, {6'b0, addrb}});
        if (data_valid) vq.push_back('{cyc, data_out});
        if (done) dq.push_back(cyc);
        if (cyc >= sc && cyc - sc < NB) busy_seen[cyc - sc] = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic run_scan(input int b, input int l, input bit au,
                            input int gmax);
        ev_t efq[$];
        ev_t evq[$];
        int  fi0, vi0, di0;
        int  t, v, s, a, done_rc, endc, bad;
        fi0 = fq.size();
        vi0 = vq.size();
        di0 = dq.size();
        done_rc = 2;
        for (int k = 0; k < NB; k++) begin
            step_at[k] = 1'b0;
            busy_exp[k] = 1'b0;
        end
        if (l > 0) begin
            t = 1;
            for (int i = 0; i < l; i++) begin
                a = (b + i) % 1024;
                efq.push_back('{t, 16'(a)});
                v = t + 1 + RL;
                evq.push_back('{v, mem[a]});
                if (au) begin
                    s = v + DW - 1;
                end else begin
                    s = v + $urandom_range(0, gmax);
                    step_at[s] = 1'b1;
                    if ($urandom_range(0, 1) == 1) step_at[v - 1] = 1'b1;
                end
                if (i == l - 1) done_rc = s + 2;
                else t = s + 1;
            end
        end
        for (int k = 1; k < done_rc; k++) busy_exp[k] = 1'b1;
        if (!au) step_at[0] = 1'b1;
        endc = done_rc + 2;
        for (int rc = 0; rc <= endc; rc++) begin
            @(posedge CLK);
            #1;
            if (rc == 0) begin
                sc = cyc;
                start = 1'b1;
                base_addr = 10'(b);
                length = 10'(l);
            end else begin
                start = (l != 0 && rc == 3);
                base_addr = 10'($urandom);
                length = 10'($urandom);
            end
            auto_mode = au;
            step = au ? ($urandom_range(0, 3) == 0) : step_at[rc];
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
        step = 1'b0;
        chk("fetch_count", fq.size() - fi0, efq.size());
        for (int i = 0; i < efq.size(); i++) begin
            if (fi0 + i < fq.size()) begin
                chk("fetch_cycle", fq[fi0 + i].c - sc, efq[i].c);
                chk("fetch_addr", fq[fi0 + i].v, efq[i].v);
            end
        end
        chk("valid_count", vq.size() - vi0, evq.size());
        for (int i = 0; i < evq.size(); i++) begin
            if (vi0 + i < vq.size()) begin
                chk("valid_cycle", vq[vi0 + i].c - sc, evq[i].c);
                chk("valid_data", vq[vi0 + i].v, evq[i].v);
            end
        end
        chk("done_count", dq.size() - di0, 1);
        if (dq.size() > di0) chk("done_cycle", dq[di0] - sc, done_rc);
        bad = 0;
        for (int k = 0; k <= endc; k++) begin
            if (busy_seen[k] != busy_exp[k]) bad++;
        end
        chk("busy_profile", bad, 0);
        if (l > 0) last_d = mem[(b + l - 1) % 1024];
        chk("data_hold", data_out, last_d);
    endtask

    initial begin
        int dn;
        for (int k = 0; k < 1024; k++) mem[k] = 16'($urandom);
        mem[4] = 16'hA001;
        mem[5] = 16'hA002;
        mem[6] = 16'hA003;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_enb", enb, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        run_scan(4, 3, 1'b0, 3);
        chk("word_a003", data_out, 16'hA003);
        run_scan(0, 1, 1'b0, 2);
        run_scan(10'h3FE, 4, 1'b0, 2);
        run_scan(int'($urandom_range(0, 1023)), 2, 1'b1, 0);
        run_scan(9, 0, 1'b0, 0);

        @(posedge CLK);
        #1;
        start = 1'b1;
        base_addr = 10'd7;
        length = 10'd3;
        auto_mode = 1'b0;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("arst_enb", enb, 0);
        chk("arst_addrb", addrb, 0);
        chk("arst_data", data_out, 0);
        chk("arst_valid", data_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        dn = 0;
        repeat (3) begin
            @(negedge CLK);
            if (done) dn++;
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (done) dn++;
        end
        chk("arst_no_done", dn, 0);
        last_d = '0;

        run_scan(20, 2, 1'b0, 1);
        for (int n = 0; n < 6; n++) begin
            run_scan(int'($urandom_range(0, 1023)),
                     int'($urandom_range(1, 6)),
                     1'($urandom_range(0, 1)), 3);
        end
        run_scan(5, 1023, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
